// File: rtl/lcd_ctrl_pkg.sv
// Shared opcode values and sequencer state encoding for the LCD command path.
// Latency: none (definitions only).
// Backpressure: not applicable.
package lcd_ctrl_pkg;

    localparam logic [3:0] OP_WRITE      = 4'd0;
    localparam logic [3:0] OP_SHIFT_U    = 4'd1;
    localparam logic [3:0] OP_SHIFT_D    = 4'd2;
    localparam logic [3:0] OP_SHIFT_L    = 4'd3;
    localparam logic [3:0] OP_SHIFT_R    = 4'd4;
    localparam logic [3:0] OP_MAX        = 4'd5;
    localparam logic [3:0] OP_MIN        = 4'd6;
    localparam logic [3:0] OP_AVG        = 4'd7;
    localparam logic [3:0] OP_CCW        = 4'd8;
    localparam logic [3:0] OP_CW         = 4'd9;
    localparam logic [3:0] OP_MIRX       = 4'd10;
    localparam logic [3:0] OP_MIRY       = 4'd11;
    localparam logic [3:0] OP_LAST_LEGAL = OP_MIRY;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_WAITQ    = 3'd2,
        ST_RDY      = 3'd3,
        ST_ACK      = 3'd4,
        ST_FORCE_WR = 3'd5,
        ST_WDONE    = 3'd6,
        ST_FIN      = 3'd7
    } seq_state_t;

    // Opcodes above MIRY have no controller meaning and are dropped from the stream.
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_LAST_LEGAL);
    endfunction

endpackage

// File: rtl/lcd_seq_watchdog.sv
// Stall watchdog: counts enabled cycles, flags expiry on the WDOG_MAX-th one.
// Latency: expire is combinational in the cycle the count reaches WDOG_MAX-1.
// Backpressure: none; the counter holds at its ceiling until cleared.
module lcd_seq_watchdog #(
    parameter int WDOG_MAX = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(WDOG_MAX + 1);

    logic [CW-1:0] cnt;

    // Count stalled cycles; any cycle outside a waiting state restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != CW'(WDOG_MAX))) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fire during the WDOG_MAX-th consecutive enabled cycle so the FSM leaves on that edge.
    always_comb begin
        expire = enable && (cnt == CW'(WDOG_MAX - 1));
    end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Fetches opcodes from the command ROM and strobes them into the LCD controller until WRITE.
// Latency: fetch-to-strobe 3 cycles when busy is low; one dead cycle after every strobe.
// Backpressure: holds each opcode in RDY while busy is high, bounded by the watchdog.
module lcd_cmd_sequencer
    import lcd_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 6,
    parameter int WDOG_MAX = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              CROM_rd,
    output logic [ADDR_W-1:0] CROM_A,
    input  logic [3:0]        CROM_Q,
    input  logic              busy,
    input  logic              done,
    output logic [3:0]        cmd,
    output logic              cmd_valid,
    output logic [ADDR_W-1:0] cmd_count,
    output logic              finished,
    output logic              script_err,
    output logic              timeout
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] COUNT_MAX = {ADDR_W{1'b1}};

    seq_state_t        state;
    seq_state_t        next_state;
    logic [ADDR_W-1:0] addr;
    logic              wd_en;
    logic              wd_expire;

    lcd_seq_watchdog #(
        .WDOG_MAX (WDOG_MAX)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (!wd_en),
        .enable (wd_en),
        .expire (wd_expire)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: script walk, handshake wait and watchdog escape.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) next_state = ST_FETCH;
            end
            ST_FETCH: begin
                next_state = ST_WAITQ;
            end
            ST_WAITQ: begin
                if (!op_is_legal(CROM_Q)) begin
                    next_state = (addr == ADDR_LAST) ? ST_FORCE_WR : ST_FETCH;
                end else begin
                    next_state = ST_RDY;
                end
            end
            ST_RDY: begin
                if (wd_expire)  next_state = ST_FIN;
                else if (!busy) next_state = ST_ACK;
            end
            ST_ACK: begin
                if (cmd == OP_WRITE)        next_state = ST_WDONE;
                else if (addr == ADDR_LAST) next_state = ST_FORCE_WR;
                else                        next_state = ST_FETCH;
            end
            ST_FORCE_WR: begin
                next_state = ST_RDY;
            end
            ST_WDONE: begin
                if (done || wd_expire) next_state = ST_FIN;
            end
            ST_FIN: begin
                if (start) next_state = ST_FETCH;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Output decode: ROM read, command strobe, watchdog enable and completion level.
    always_comb begin
        CROM_rd   = (state == ST_FETCH);
        cmd_valid = (state == ST_RDY) && !busy;
        wd_en     = ((state == ST_RDY) && busy) || (state == ST_WDONE);
        finished  = (state == ST_FIN);
    end

    assign CROM_A = addr;

    // Datapath: address walk, opcode capture, accepted-command count and sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr       <= '0;
            cmd        <= OP_WRITE;
            cmd_count  <= '0;
            script_err <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_FIN: begin
                    if (start) begin
                        addr       <= '0;
                        cmd_count  <= '0;
                        script_err <= 1'b0;
                        timeout    <= 1'b0;
                    end
                end
                ST_WAITQ: begin
                    cmd <= CROM_Q;
                    if (!op_is_legal(CROM_Q)) begin
                        script_err <= 1'b1;
                        if (addr != ADDR_LAST) addr <= addr + 1'b1;
                    end
                end
                ST_RDY: begin
                    if (wd_expire) timeout <= 1'b1;
                end
                ST_ACK: begin
                    if (cmd_count != COUNT_MAX) cmd_count <= cmd_count + 1'b1;
                    if ((cmd != OP_WRITE) && (addr != ADDR_LAST)) addr <= addr + 1'b1;
                end
                ST_FORCE_WR: begin
                    cmd        <= OP_WRITE;
                    script_err <= 1'b1;
                end
                ST_WDONE: begin
                    if (!done && wd_expire) timeout <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Bench for lcd_cmd_sequencer: scripted and random ROMs checked against a script-walk model.
// Latency: not applicable.
// Backpressure: busy is driven fixed or randomly by a single driver process.
module tb_lcd_cmd_sequencer;

    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;
    localparam int SAT   = DEPTH - 1;
    localparam int WD_A  = 100;
    localparam int WD_B  = 15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Main instance.
    logic          start, crom_rd, busy, done, cmd_valid, finished, script_err, timeout;
    logic [AW-1:0] crom_a, cmd_count;
    logic [3:0]    crom_q, cmd;

    // Short-watchdog instance, used only for the stuck-busy case.
    logic          start_b, crom_rd_b, busy_b, done_b, cmd_valid_b, finished_b, script_err_b, timeout_b;
    logic [AW-1:0] crom_a_b, cmd_count_b;
    logic [3:0]    crom_q_b, cmd_b;

    lcd_cmd_sequencer #(.ADDR_W(AW), .WDOG_MAX(WD_A)) dut (
        .clk(clk), .reset(reset), .start(start), .CROM_rd(crom_rd), .CROM_A(crom_a),
        .CROM_Q(crom_q), .busy(busy), .done(done), .cmd(cmd), .cmd_valid(cmd_valid),
        .cmd_count(cmd_count), .finished(finished), .script_err(script_err), .timeout(timeout)
    );

    lcd_cmd_sequencer #(.ADDR_W(AW), .WDOG_MAX(WD_B)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .CROM_rd(crom_rd_b), .CROM_A(crom_a_b),
        .CROM_Q(crom_q_b), .busy(busy_b), .done(done_b), .cmd(cmd_b), .cmd_valid(cmd_valid_b),
        .cmd_count(cmd_count_b), .finished(finished_b), .script_err(script_err_b), .timeout(timeout_b)
    );

    // Command ROM: one-cycle read latency.
    logic [3:0] rom [DEPTH];
    always @(posedge clk) begin
        if (crom_rd)   crom_q   <= rom[crom_a];
        if (crom_rd_b) crom_q_b <= rom[crom_a_b];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Busy driver: fixed level or random, changing just after each rising edge.
    logic rand_busy  = 1'b0;
    logic busy_force = 1'b0;
    always @(posedge clk) begin
        #2;
        busy = rand_busy ? ($urandom_range(0, 2) == 0) : busy_force;
    end

    // Strobe monitor.
    logic [3:0] got_q[$];
    logic       prev_vld = 1'b0;
    int         b_strobes = 0;
    always @(negedge clk) begin
        if (cmd_valid) begin
            check("strobe_while_busy", busy, 0);
            check("strobe_back_to_back", prev_vld, 0);
            got_q.push_back(cmd);
        end
        prev_vld = cmd_valid;
        if (cmd_valid_b) b_strobes++;
    end

    // Reference: walk the script, drop illegal opcodes, stop after WRITE, else append a WRITE.
    logic [3:0] exp_q[$];
    logic       exp_err;
    task automatic build_expected();
        bit wrote;
        wrote = 0;
        exp_q.delete();
        exp_err = 0;
        for (int a = 0; a < DEPTH && !wrote; a++) begin
            if (rom[a] > 4'd11) begin
                exp_err = 1;
            end else begin
                exp_q.push_back(rom[a]);
                if (rom[a] == 4'd0) wrote = 1;
            end
        end
        if (!wrote) begin
            exp_q.push_back(4'd0);
            exp_err = 1;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_crom_rd"},    crom_rd, 0);
        check({tag, "_crom_a"},     crom_a, 0);
        check({tag, "_cmd"},        cmd, 0);
        check({tag, "_cmd_valid"},  cmd_valid, 0);
        check({tag, "_cmd_count"},  cmd_count, 0);
        check({tag, "_finished"},   finished, 0);
        check({tag, "_script_err"}, script_err, 0);
        check({tag, "_timeout"},    timeout, 0);
    endtask

    // Wait for all expected strobes, pulse done, then compare the run against the model.
    task automatic finish_run(input string tag);
        int n;
        int exp_cnt;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_nstrobe"}, got_q.size(), exp_q.size());
        repeat (3) @(posedge clk);
        #1 done = 1'b1;
        @(posedge clk); #1 done = 1'b0;
        n = 0;
        while (!finished && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_finished"}, finished, 1);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_op%0d", tag, i), got_q[i], exp_q[i]);
        exp_cnt = (exp_q.size() > SAT) ? SAT : exp_q.size();
        check({tag, "_cmd_count"},  cmd_count, exp_cnt);
        check({tag, "_script_err"}, script_err, exp_err);
        check({tag, "_timeout"},    timeout, 0);
        repeat (4) @(negedge clk);
        check({tag, "_no_extra"},   got_q.size(), exp_q.size());
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; done = 1'b0;
        start_b = 1'b0; busy_b = 1'b1; done_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) rom[i] = 4'd7;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1 reset = 1'b0;

        // Basic script, busy low.
        rom[0] = 4'd5; rom[1] = 4'd1; rom[2] = 4'd0;
        got_q.delete(); build_expected();
        pulse_start();
        finish_run("basic");

        // Long busy after reset: nothing issued until the first busy-low cycle.
        busy_force = 1'b1;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        rom[0] = 4'd2; rom[1] = 4'd9; rom[2] = 4'd0;
        got_q.delete(); build_expected();
        pulse_start();
        repeat (70) @(posedge clk);
        check("busy70_none", got_q.size(), 0);
        check("busy70_timeout", timeout, 0);
        #1 busy_force = 1'b0;
        @(negedge clk);
        check("busy70_first_vld", cmd_valid, 1);
        check("busy70_first_cmd", cmd, 4'd2);
        finish_run("busy70");

        // Illegal opcode skipped; restart from FIN.
        rom[0] = 4'd3; rom[1] = 4'd13; rom[2] = 4'd0;
        got_q.delete(); build_expected();
        pulse_start();
        finish_run("illegal");

        // Script with no WRITE: every entry issued, then a forced WRITE.
        for (int i = 0; i < DEPTH; i++) rom[i] = 4'd4;
        got_q.delete(); build_expected();
        pulse_start();
        finish_run("no_write");

        // Stuck busy on the short-watchdog instance.
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (finished_b) break;
            n++;
        end
        check("wdog_cycles",   n, 2 + WD_B);
        check("wdog_timeout",  timeout_b, 1);
        check("wdog_finished", finished_b, 1);
        check("wdog_strobes",  b_strobes, 0);
        check("wdog_count",    cmd_count_b, 0);

        // Reset in the middle of RDY, then a clean restart from address 0.
        busy_force = 1'b1;
        rom[0] = 4'd6; rom[1] = 4'd8; rom[2] = 4'd0;
        pulse_start();
        repeat (10) @(posedge clk);
        #3 reset = 1'b1;
        @(negedge clk);
        check_reset_values("midreset");
        @(posedge clk); #1 reset = 1'b0;
        busy_force = 1'b0;
        got_q.delete(); build_expected();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("midreset_fetch_rd", crom_rd, 1);
        check("midreset_fetch_a",  crom_a, 0);
        finish_run("midreset");

        // Random scripts with random backpressure.
        rand_busy = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DEPTH; i++) rom[i] = 4'($urandom_range(0, 15));
            got_q.delete(); build_expected();
            pulse_start();
            finish_run($sformatf("rand%0d", r));
        end
        rand_busy = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
